pci_bridge_wb_target_mem: RTL and testbench

PCI_BRIDGE_WB_TARGET_MEM -- requirements
Module: pci_bridge_wb_target_mem

---
 rtl/pci_bridge_wb_target_mem.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_pci_bridge_wb_target_mem.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_bridge_wb_target_mem.sv
// ---------------------------------------------------------------------------
// pci_bridge_wb_target_mem
//
// WISHBONE B3 slave memory that sits behind the PCI bridge's WISHBONE master
// port. It serves classic and registered-feedback burst cycles (linear and
// wrap-4/8/16). It inserts a fixed number of wait states before the first
// ACK_O of every cycle. It answers addresses outside its window with ERR_O.
//
// Optional feature macro: PCI_BRIDGE_WB_TARGET_RETRY_EN
//   defined   : every RETRY_PERIOD-th in-window cycle start is answered with
//               RTY_O instead of being served.
//   undefined : RTY_O is tied low and RETRY_PERIOD has no effect.
//
// Parameters
//   ADDR_BASE    byte base address of the memory window
//   DEPTH_LOG2   log2 of the number of 32-bit words
//   WAIT_STATES  idle cycles before the first ACK_O of a cycle (0..15)
//   RETRY_PERIOD retry spacing in cycle starts (2..255, macro builds only)
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   ADR_I  [31:0]    byte address from the bridge
//   DAT_I  [31:0]    write data from the bridge
//   DAT_O  [31:0]    read data to the bridge, zero outside read ACK cycles
//   SEL_I  [3:0]     byte lane selects
//   CYC_I, STB_I, WE_I   cycle, strobe, write enable
//   CTI_I  [2:0]     cycle type (000 classic, 010 incrementing, 111 end)
//   BTE_I  [1:0]     burst type (00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16)
//   ACK_O, RTY_O, ERR_O  cycle terminations, mutually exclusive
// ---------------------------------------------------------------------------
module pci_bridge_wb_target_mem #(
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2   = 8,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned RETRY_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic [3:0]  SEL_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [2:0]  CTI_I,
  input  logic [1:0]  BTE_I,
  output logic        ACK_O,
  output logic        RTY_O,
  output logic        ERR_O
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  // The wait counter is loaded with WAIT_STATES-1 and the FSM leaves WAIT
  // when it reads zero, so WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [2:0] CTI_INCR = 3'b010;

  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] MASK_W4  = DEPTH_LOG2'(3);
  localparam logic [DEPTH_LOG2-1:0] MASK_W8  = DEPTH_LOG2'(7);
  localparam logic [DEPTH_LOG2-1:0] MASK_W16 = DEPTH_LOG2'(15);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_TERM
  } state_e;

  // -------------------------------------------------------------------------
  // Reset release synchroniser.
  // Assertion reaches the core at once. Release is retimed to clk, so the
  // core leaves reset on the first posedge after rst_n rises and samples its
  // first cycle on the second posedge.
  // -------------------------------------------------------------------------
  logic rst_sync_q;
  logic core_rst_n;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  assign core_rst_n = rst_sync_q;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic [31:0]           offset;
  logic                  in_window;
  logic [DEPTH_LOG2-1:0] start_addr;

  assign offset     = ADR_I - ADDR_BASE;
  // Below-base addresses wrap to large offsets, so both limits are tested
  // explicitly rather than relying on the subtraction alone.
  assign in_window  = (ADR_I >= ADDR_BASE) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign start_addr = offset[DEPTH_LOG2+1:2];

  // -------------------------------------------------------------------------
  // Burst address sequencing: wrap bursts only advance the low bits picked by
  // the mask; the bits above the mask stay fixed.
  // -------------------------------------------------------------------------
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DEPTH_LOG2-1:0] wrap_mask;
  logic [DEPTH_LOG2-1:0] addr_next;

  always_comb begin
    wrap_mask = '1;
    unique case (BTE_I)
      2'b01:   wrap_mask = MASK_W4;
      2'b10:   wrap_mask = MASK_W8;
      2'b11:   wrap_mask = MASK_W16;
      default: wrap_mask = '1;
    endcase
  end

  assign addr_next = (addr_q & ~wrap_mask) | ((addr_q + ADDR_ONE) & wrap_mask);

  // -------------------------------------------------------------------------
  // Retry scheduling
  // -------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   start_in_window;
  logic   retry_hit;

  assign start_in_window = (state_q == S_IDLE) && CYC_I && STB_I && in_window;

`ifdef PCI_BRIDGE_WB_TARGET_RETRY_EN
  localparam logic [7:0] RETRY_LAST = 8'(RETRY_PERIOD - 1);

  logic [7:0] retry_cnt_q, retry_cnt_d;

  assign retry_hit = (retry_cnt_q == RETRY_LAST);

  // Every in-window start is counted; the one that hits the period is
  // retried and restarts the count.
  always_comb begin
    retry_cnt_d = retry_cnt_q;
    if (start_in_window) begin
      retry_cnt_d = retry_hit ? 8'd0 : retry_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      retry_cnt_q <= 8'd0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
    end
  end
`else
  logic [7:0] unused_retry_period;

  assign retry_hit           = 1'b0;
  assign unused_retry_period = 8'(RETRY_PERIOD);
`endif

  // -------------------------------------------------------------------------
  // Cycle FSM
  // -------------------------------------------------------------------------
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       term_rty_q, term_rty_d;
  logic       ack;

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    term_rty_d = term_rty_q;
    ack        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (CYC_I && STB_I) begin
          if (!in_window) begin
            state_d    = S_TERM;
            term_rty_d = 1'b0;
          end else if (retry_hit) begin
            state_d    = S_TERM;
            term_rty_d = 1'b1;
          end else begin
            addr_d = start_addr;
            if (WAIT_STATES == 0) begin
              state_d = S_ACK;
            end else begin
              state_d    = S_WAIT;
              wait_cnt_d = WAIT_LOAD;
            end
          end
        end
      end

      S_WAIT: begin
        if (!CYC_I) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      S_ACK: begin
        if (!CYC_I) begin
          state_d = S_IDLE;
        end else if (STB_I) begin
          // A beat completes only while the strobe is high. With the strobe
          // low the state and address simply hold.
          ack    = 1'b1;
          addr_d = addr_next;
          if (CTI_I != CTI_INCR) begin
            state_d = S_IDLE;
          end
        end
      end

      S_TERM: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      term_rty_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      term_rty_q <= term_rty_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  logic        mem_we;

  assign mem_we = ack && WE_I;

  // NOTE: the memory array is deliberately left out of reset; contents
  // survive a reset and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (SEL_I[b]) begin
          mem[addr_q][8*b +: 8] <= DAT_I[8*b +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. ACK_O is derived from state and strobe so a paused burst drops
  // it in the same cycle. All outputs fall with reset because the state
  // register clears asynchronously.
  // -------------------------------------------------------------------------
  assign ACK_O = ack;
  assign ERR_O = (state_q == S_TERM) && !term_rty_q;
`ifdef PCI_BRIDGE_WB_TARGET_RETRY_EN
  assign RTY_O = (state_q == S_TERM) && term_rty_q;
`else
  assign RTY_O = 1'b0;
`endif
  assign DAT_O = (ack && !WE_I) ? mem[addr_q] : 32'd0;

endmodule

// File: tb/tb_pci_bridge_wb_target_mem.sv
// ---------------------------------------------------------------------------
// Testbench for pci_bridge_wb_target_mem.
// A driver issues classic and burst cycles. For every termination it expects,
// it pushes the termination kind and, for reads, the data from a word-level
// reference memory. A monitor pops one entry per observed termination on the
// falling edge. Retry behaviour follows PCI_BRIDGE_WB_TARGET_RETRY_EN.
// ---------------------------------------------------------------------------
module tb_pci_bridge_wb_target_mem;

  localparam logic [31:0] ADDR_BASE    = 32'h0000_0000;
  localparam int          DEPTH_LOG2   = 8;
  localparam int          WAIT_STATES  = 1;
  localparam int          RETRY_PERIOD = 4;
  localparam logic [31:0] WIN_BYTES    = 32'd4 << DEPTH_LOG2;
`ifdef PCI_BRIDGE_WB_TARGET_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ADR_I = '0, DAT_I = '0, DAT_O;
  logic [3:0]  SEL_I = '0;
  logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic [2:0]  CTI_I = '0;
  logic [1:0]  BTE_I = '0;
  logic        ACK_O, RTY_O, ERR_O;

  pci_bridge_wb_target_mem #(
    .ADDR_BASE   (ADDR_BASE),
    .DEPTH_LOG2  (DEPTH_LOG2),
    .WAIT_STATES (WAIT_STATES),
    .RETRY_PERIOD(RETRY_PERIOD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ADR_I(ADR_I),
    .DAT_I(DAT_I),
    .DAT_O(DAT_O),
    .SEL_I(SEL_I),
    .CYC_I(CYC_I),
    .STB_I(STB_I),
    .WE_I (WE_I),
    .CTI_I(CTI_I),
    .BTE_I(BTE_I),
    .ACK_O(ACK_O),
    .RTY_O(RTY_O),
    .ERR_O(ERR_O)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {T_ACK, T_ERR, T_RTY} term_e;
  typedef struct packed {
    term_e       kind;
    logic [31:0] data;
    logic        is_read;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [256];
  int          checks = 0;
  int          errors = 0;
  int          starts = 0;   // in-window cycle starts since the last reset
  int          rty_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input term_e k, input logic [31:0] d, input logic rd);
    exp_t e;
    e.kind    = k;
    e.data    = d;
    e.is_read = rd;
    exp_q.push_back(e);
  endtask

  // Kind of termination the next in-window start should get.
  function automatic term_e start_kind();
    if (RETRY_EN) begin
      starts++;
      if (starts % RETRY_PERIOD == 0) return T_RTY;
    end
    return T_ACK;
  endfunction

  function automatic int next_word(input int w, input logic [1:0] bte);
    int n;
    case (bte)
      2'b00:   n = 256;
      2'b01:   n = 4;
      2'b10:   n = 8;
      default: n = 16;
    endcase
    return (w / n) * n + ((w % n) + 1) % n;
  endfunction

  // Monitor: one expectation per observed termination.
  exp_t  mon_e;
  term_e mon_k;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!(ACK_O && !WE_I)) check("dat_idle", DAT_O, 32'd0);
      if (ACK_O || ERR_O || RTY_O) begin
        check("term_onehot", 32'(ACK_O) + 32'(ERR_O) + 32'(RTY_O), 32'd1);
        if (RTY_O) rty_seen++;
        mon_k = ACK_O ? T_ACK : (ERR_O ? T_ERR : T_RTY);
        if (exp_q.size() == 0) begin
          check("unexpected_term", 32'(mon_k) + 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("term_kind", 32'(mon_k), 32'(mon_e.kind));
          if (mon_e.is_read && ACK_O) check("rd_data", DAT_O, mon_e.data);
        end
      end
    end
  end

  // Counts falling edges before the one that carries a termination.
  task automatic wait_term(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ACK_O || ERR_O || RTY_O) return;
      n++;
    end
    check("term_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_ack"}, 32'(ACK_O), 32'd0);
    check({tag, "_err"}, 32'(ERR_O), 32'd0);
    check({tag, "_rty"}, 32'(RTY_O), 32'd0);
    check({tag, "_dat"}, DAT_O, 32'd0);
    rst_n  = 1'b1;
    starts = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wb_single(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, input bit retry_ok, input string tag);
    bit    done;
    term_e k;
    int    n;
    int    w;
    done = 0;
    while (!done) begin
      w = int'(adr[9:2]);
      if (adr < ADDR_BASE || adr >= ADDR_BASE + WIN_BYTES) k = T_ERR;
      else k = start_kind();
      push_exp(k, model[w], !we);
      ADR_I = adr; DAT_I = wdat; SEL_I = sel; WE_I = we;
      CTI_I = 3'b000; BTE_I = 2'b00; CYC_I = 1'b1; STB_I = 1'b1;
      wait_term(n);
      check({tag, "_lat"}, 32'(n), (k == T_ACK) ? 32'(WAIT_STATES + 1) : 32'd1);
      @(posedge clk);
      #1;
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
      if (k == T_ACK && we) begin
        for (int i = 0; i < 4; i++) if (sel[i]) model[w][8*i +: 8] = wdat[8*i +: 8];
      end
      done = (k != T_RTY) || !retry_ok;
    end
  endtask

  // Burst of nbeats; beat b writes wbase+b. gap_beat drops STB for one cycle
  // before that beat; rst_beat asserts reset while that beat is acknowledged.
  task automatic wb_burst(input logic [31:0] adr, input logic [1:0] bte, input int nbeats,
                          input logic we, input logic [31:0] wbase, input int gap_beat,
                          input int rst_beat, input string tag);
    bit    done;
    term_e k;
    int    n;
    int    w;
    done = 0;
    while (!done) begin
      w = int'(adr[9:2]);
      k = start_kind();
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; BTE_I = bte; SEL_I = 4'hF;
      for (int b = 1; b <= nbeats; b++) begin
        ADR_I = ADDR_BASE + 32'(w * 4);
        DAT_I = wbase + 32'(b);
        CTI_I = (b == nbeats) ? 3'b111 : 3'b010;
        if (b == gap_beat) begin
          STB_I = 1'b0;
          @(posedge clk);
          #1;
          STB_I = 1'b1;
        end
        if (b == rst_beat) begin
          #1;
          rst_n = 1'b0;
          #1;
          check({tag, "_rst_ack"}, 32'(ACK_O), 32'd0);
          check({tag, "_rst_dat"}, DAT_O, 32'd0);
          check({tag, "_rst_err"}, 32'(ERR_O | RTY_O), 32'd0);
          starts = 0;
          break;
        end
        push_exp((b == 1) ? k : T_ACK, model[w], !we);
        wait_term(n);
        if (b == 1) check({tag, "_lat"}, 32'(n), (k == T_ACK) ? 32'(WAIT_STATES + 1) : 32'd1);
        else        check({tag, "_gapless"}, 32'(n), 32'd0);
        @(posedge clk);
        #1;
        if (k == T_RTY) break;
        if (we) model[w] = wbase + 32'(b);
        w = next_word(w, bte);
      end
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; CTI_I = 3'b000;
      done = (k != T_RTY);
    end
  endtask

  initial begin
    do_reset("reset");

    // Classic write then read with one wait state.
    wb_single(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 1, "wr10");
    wb_single(32'h10, 1'b0, 32'h0, 4'hF, 1, "rd10");

    // Byte-lane merge and an all-lanes-off write.
    wb_single(32'h20, 1'b1, 32'h1122_3344, 4'hF, 1, "wr20");
    wb_single(32'h20, 1'b1, 32'hAABB_CCDD, 4'b0010, 1, "wr20_lane1");
    wb_single(32'h20, 0, 32'h0, 4'hF, 1, "rd20");
    wb_single(32'h10, 1'b1, 32'h0, 4'h0, 1, "wr10_sel0");
    wb_single(32'h10, 1'b0, 32'h0, 4'hF, 1, "rd10_sel0");

    // Linear fill of words 0..3, then a six-beat wrap-4 read from 0x08.
    wb_burst(32'h00, 2'b00, 4, 1'b1, 32'hA0A0_0000, 0, 0, "fill0");
    wb_burst(32'h08, 2'b01, 6, 1'b0, 32'h0, 0, 0, "wrap4");

    // Wrap-8 write from word 23 and read back, each with a strobe pause.
    wb_burst(32'h5C, 2'b10, 5, 1'b1, 32'hB000_0000, 3, 0, "wrap8_wr");
    wb_burst(32'h5C, 2'b10, 5, 1'b0, 32'h0, 2, 0, "wrap8_rd");
    wb_single(32'h40, 1'b0, 32'h0, 4'hF, 1, "rd_w16");

    // Out-of-window accesses end in ERR and leave memory alone.
    wb_single(32'h400, 1'b0, 32'h0, 4'hF, 1, "oow_rd");
    wb_single(32'h400, 1'b1, 32'hFFFF_FFFF, 4'hF, 1, "oow_wr");
    wb_single(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, 1, "oow_top");
    wb_single(32'h00, 1'b0, 32'h0, 4'hF, 1, "rd_w0");

    // CYC dropped during the wait state: no ACK, no write.
    wb_single(32'h30, 1'b1, 32'h0BAD_F00D, 4'hF, 1, "wr30");
    begin
      term_e k;
      k = start_kind();
      if (k == T_RTY) push_exp(T_RTY, 32'h0, 1'b0);
      ADR_I = 32'h30; DAT_I = 32'h5555_5555; SEL_I = 4'hF; WE_I = 1'b1;
      CTI_I = 3'b000; CYC_I = 1'b1; STB_I = 1'b1;
      @(posedge clk);
      #1;
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    wb_single(32'h30, 1'b0, 32'h0, 4'hF, 1, "rd30_abort");

    // Reset in beat 3 of an eight-beat write burst.
    wb_burst(32'h100, 2'b00, 8, 1'b1, 32'hC000_0000, 0, 0, "fill64");
    wb_burst(32'h100, 2'b00, 8, 1'b1, 32'hD000_0000, 0, 3, "rst_burst");
    do_reset("reset_mid");
    for (int i = 0; i < 8; i++) wb_single(32'h100 + 32'(4 * i), 1'b0, 32'h0, 4'hF, 1, "rd_after_rst");

    // Eight classic reads straight after reset.
    do_reset("reset_rty");
    rty_seen = 0;
    for (int i = 0; i < 8; i++) wb_single(32'h10, 1'b0, 32'h0, 4'hF, 0, "rty_rd");
    check("rty_count", 32'(rty_seen), RETRY_EN ? 32'd2 : 32'd0);

    repeat (4) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
